// File: rtl/gf8_syndrome_seq_if.sv
// Codeword-in / syndromes-out bus of the sequential GF(8) syndrome generator.
// slave = the generator, master = upstream deinterleaver plus downstream locator.
interface gf8_syndrome_seq_if #(
   parameter int N_SYM = 7,
   parameter int N_SYN = 2
);
   logic [3*N_SYM-1:0] cw_i;
   logic               cw_valid_i;
   logic               cw_ready_o;
   logic [3*N_SYN-1:0] syn_o;
   logic               err_o;
   logic               syn_valid_o;
   logic               syn_ready_i;
   logic               busy_o;

   modport slave (
      input  cw_i, cw_valid_i, syn_ready_i,
      output cw_ready_o, syn_o, err_o, syn_valid_o, busy_o
   );

   modport master (
      output cw_i, cw_valid_i, syn_ready_i,
      input  cw_ready_o, syn_o, err_o, syn_valid_o, busy_o
   );
endinterface

// File: rtl/gf8_syndrome_seq.sv
// RS(7,5) syndromes over GF(8) by Horner evaluation on one shared multiplier; N_SYM*N_SYN cycles
// from accept to syn_valid_o, one codeword in flight, DONE holds until syn_ready_i.
module gf8_syndrome_seq #(
   parameter int N_SYM = 7,
   parameter int N_SYN = 2
) (
   input  logic               clk,
   input  logic               rst,
   gf8_syndrome_seq_if.slave  bus
);
   localparam logic [2:0] IDX_MAX = 3'(N_SYM - 1);
   localparam logic [2:0] J_LAST  = 3'(N_SYN);

   generate
      if (N_SYM < 2 || N_SYM > 7 || N_SYN < 1 || N_SYN > 6 || N_SYN >= N_SYM) begin : g_bad_params
         $error("gf8_syndrome_seq: illegal N_SYM/N_SYN");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              acc_q, acc_d;
   logic [2:0]              idx_q, idx_d;
   logic [2:0]              j_q, j_d;
   logic [N_SYM-1:0][2:0]   cw_q, cw_d;
   logic [N_SYN-1:0][2:0]   syn_q, syn_d;
   logic                    err_q, err_d;

   logic       cw_fire;
   logic       last_sym;
   logic       last_syn;
   logic [2:0] sym;
   logic [2:0] mul_op2;
   logic [2:0] mul_out;
   logic [2:0] acc_next;
   logic       cw_ready;
   logic       syn_valid;
   logic       busy;

   function automatic logic [2:0] alpha_pow(input logic [2:0] j);
      case (j)
         3'd1:    return 3'b010;
         3'd2:    return 3'b100;
         3'd3:    return 3'b011;
         3'd4:    return 3'b110;
         3'd5:    return 3'b111;
         3'd6:    return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   assign mul_op2 = alpha_pow(j_q);

   gf_mult_3 u_mult (
      .a_i (acc_q),
      .b_i (mul_op2),
      .p_o (mul_out)
   );

   assign cw_fire  = bus.cw_valid_i && (state_q == IDLE);
   assign last_sym = (idx_q == 3'd0);
   assign last_syn = last_sym && (j_q == J_LAST);
   assign acc_next = mul_out ^ sym;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cw_fire) state_d = CALC;
         CALC:    if (last_syn) state_d = DONE;
         DONE:    if (bus.syn_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cw_ready  = (state_q == IDLE);
      syn_valid = (state_q == DONE);
      busy      = (state_q == CALC) || (state_q == DONE);
   end

   always_comb begin
      sym = 3'b000;
      for (int k = 0; k < N_SYM; k++) begin
         if (idx_q == 3'(k)) sym = cw_q[k];
      end
   end

   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      j_d   = j_q;
      cw_d  = cw_q;
      syn_d = syn_q;
      err_d = err_q;
      case (state_q)
         IDLE: begin
            if (cw_fire) begin
               cw_d  = bus.cw_i;
               acc_d = 3'b000;
               idx_d = IDX_MAX;
               j_d   = 3'd1;
            end
         end
         CALC: begin
            if (last_sym) begin
               // S_j slot is (j-1); err_o follows the fully written set
               for (int k = 0; k < N_SYN; k++) begin
                  if (j_q == 3'(k + 1)) syn_d[k] = acc_next;
               end
               if (last_syn) err_d = |syn_d;
               acc_d = 3'b000;
               idx_d = IDX_MAX;
               j_d   = j_q + 3'd1;
            end else begin
               acc_d = acc_next;
               idx_d = idx_q - 3'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         idx_q <= '0;
         j_q   <= '0;
         cw_q  <= '0;
         syn_q <= '0;
         err_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
         j_q   <= j_d;
         cw_q  <= cw_d;
         syn_q <= syn_d;
         err_q <= err_d;
      end
   end

   assign bus.cw_ready_o  = cw_ready;
   assign bus.syn_valid_o = syn_valid;
   assign bus.busy_o      = busy;
   assign bus.syn_o       = syn_q;
   assign bus.err_o       = err_q;
endmodule

// GF(8) multiply, field polynomial x^3+x+1; x^3 folds to x+1, x^4 to x^2+x.
module gf_mult_3 (
   input  logic [2:0] a_i,
   input  logic [2:0] b_i,
   output logic [2:0] p_o
);
   logic [4:0] p;

   always_comb begin
      p[0] = a_i[0] & b_i[0];
      p[1] = (a_i[0] & b_i[1]) ^ (a_i[1] & b_i[0]);
      p[2] = (a_i[0] & b_i[2]) ^ (a_i[1] & b_i[1]) ^ (a_i[2] & b_i[0]);
      p[3] = (a_i[1] & b_i[2]) ^ (a_i[2] & b_i[1]);
      p[4] = a_i[2] & b_i[2];
      p_o  = {p[2] ^ p[4], p[1] ^ p[3] ^ p[4], p[0] ^ p[3]};
   end
endmodule

// File: tb/tb_gf8_syndrome_seq.sv
// Directed and random codewords through gf8_syndrome_seq; expected syndromes queued at accept.
module tb_gf8_syndrome_seq;
   localparam int N_SYM = 7;
   localparam int N_SYN = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gf8_syndrome_seq_if #(.N_SYM(N_SYM), .N_SYN(N_SYN)) bus ();

   gf8_syndrome_seq #(.N_SYM(N_SYM), .N_SYN(N_SYN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [5:0] exp_syn_q[$];
   logic       exp_err_q[$];
   logic [5:0] cur_syn;
   logic       cur_err;

   function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] x;
      logic [2:0] r;
      x = {1'b0, a};
      r = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (b[i]) r = r ^ x[2:0];
         x = x << 1;
         if (x[3]) x = x ^ 4'b1011;
      end
      return r;
   endfunction

   // Direct sum c_i * (alpha^j)^i, independent of Horner ordering
   function automatic logic [5:0] model_syn(input logic [20:0] cw);
      logic [5:0] s;
      logic [2:0] aj, p, acc, c;
      s = '0;
      for (int j = 1; j <= N_SYN; j++) begin
         aj = 3'b001;
         for (int t = 0; t < j; t++) aj = gmul(aj, 3'b010);
         acc = 3'b000;
         p   = 3'b001;
         for (int i = 0; i < N_SYM; i++) begin
            c   = cw[3*i +: 3];
            acc = acc ^ gmul(c, p);
            p   = gmul(p, aj);
         end
         s[3*(j-1) +: 3] = acc;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cw_ready"},  32'(bus.cw_ready_o),  32'd1);
      chk({tag, "_syn"},       32'(bus.syn_o),       32'd0);
      chk({tag, "_err"},       32'(bus.err_o),       32'd0);
      chk({tag, "_syn_valid"}, 32'(bus.syn_valid_o), 32'd0);
      chk({tag, "_busy"},      32'(bus.busy_o),      32'd0);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge
   task automatic send(input logic [20:0] cw, input bit push, input logic [5:0] exp_syn);
      int n;
      bus.cw_i       = cw;
      bus.cw_valid_i = 1'b1;
      n = 0;
      while (bus.cw_ready_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 100), 32'd1);
      if (push) begin
         exp_syn_q.push_back(exp_syn);
         exp_err_q.push_back(exp_syn != 6'd0);
      end
      @(negedge clk);
      bus.cw_valid_i = 1'b0;
      bus.cw_i       = ~cw;
      chk("calc_busy",     32'(bus.busy_o),     32'd1);
      chk("calc_cw_ready", 32'(bus.cw_ready_o), 32'd0);
   endtask

   task automatic wait_result(input int hold);
      int cyc;
      cyc = 0;
      while (bus.syn_valid_o !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(N_SYM * N_SYN));
      cur_syn = exp_syn_q.pop_front();
      cur_err = exp_err_q.pop_front();
      chk("syn", 32'(bus.syn_o), 32'(cur_syn));
      chk("err", 32'(bus.err_o), 32'(cur_err));
      for (int k = 0; k < hold; k++) begin
         bus.cw_valid_i = 1'b1;
         bus.cw_i       = 21'h1;
         @(negedge clk);
         chk("hold_valid",    32'(bus.syn_valid_o), 32'd1);
         chk("hold_syn",      32'(bus.syn_o),       32'(cur_syn));
         chk("hold_cw_ready", 32'(bus.cw_ready_o),  32'd0);
      end
      bus.cw_valid_i  = 1'b0;
      bus.syn_ready_i = 1'b1;
      @(negedge clk);
      bus.syn_ready_i = 1'b0;
      chk("post_valid",    32'(bus.syn_valid_o), 32'd0);
      chk("post_cw_ready", 32'(bus.cw_ready_o),  32'd1);
      chk("post_busy",     32'(bus.busy_o),      32'd0);
      chk("post_syn_kept", 32'(bus.syn_o),       32'(cur_syn));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [20:0] r;
      bus.cw_i        = '0;
      bus.cw_valid_i  = 1'b0;
      bus.syn_ready_i = 1'b0;
      rst             = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("reset");

      send(21'h0, 1'b1, 6'b000_000);      wait_result(0);
      send(21'h73, 1'b1, 6'b000_000);     wait_result(0);
      send(21'h1, 1'b1, 6'b001_001);      wait_result(0);
      send(21'h8, 1'b1, 6'b100_010);      wait_result(0);
      send(21'h40000, 1'b1, 6'b111_101);  wait_result(10);

      // Abort on the fifth CALC cycle; nothing is queued for this word
      send(21'h12345, 1'b0, 6'b000_000);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("abort");
      repeat (20) @(negedge clk);
      chk("abort_no_valid", 32'(bus.syn_valid_o), 32'd0);

      send(21'h73, 1'b1, 6'b000_000);     wait_result(0);

      for (int t = 0; t < 4; t++) begin
         r = 21'($urandom);
         send(r, 1'b1, model_syn(r));
         wait_result(int'($urandom_range(0, 2)));
      end

      chk("queue_drained", 32'(exp_syn_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
